hd44780_bus_reader: RTL and testbench
=====================================

Name: hd44780_bus_reader

Overview:
- Read-side engine for the HD44780 4-bit parallel bus; the counterpart to the existing write path.
- Drives R/~W high, issues two E strobes and samples D7..D4 on each, then reassembles a byte.
- Supported reads: busy flag + address counter (RS=0) or one data RAM byte (RS=1).
- Optional busy-poll mode repeats the RS=0 read until BF clears or a poll limit is hit.
- The top level muxes lcd_rs/lcd_e with the writer and tristates lcd_data whenever bus_req is high.

Parameters:
- SYSFREQ, 48_000_000, system clock in Hz; documentation only, the counts below are pre-computed for it.
- SETUP_CLKS, 3, RS/RW setup before E rises (tAS ≥ 40 ns).
- E_HIGH_CLKS, 24, E high width (PW_EH ≥ 450 ns, covers tDDR 360 ns).
- E_LOW_CLKS, 24, E low time after each strobe (tcycE ≥ 1000 ns total).
- MAX_POLLS, 255, byte reads allowed in poll mode before timeout.
- PHASE_BITS, 5, width of the phase counter; must hold the largest *_CLKS value.

Ports:
- CLK_I  in  1  system clock
- RST_I  in  1  asynchronous reset, active-high
- start_strobe  in  1  one-cycle request; ignored unless idle
- rs_sel  in  1  0 = BF/address read, 1 = data RAM read; captured on start
- poll_mode  in  1  captured on start; honoured only when rs_sel=0
- lcd_data_in  in  4  D7..D4 from the pad input buffers
- lcd_rs  out  1  RS to the LCD
- lcd_rw  out  1  R/~W to the LCD
- lcd_e  out  1  E to the LCD
- bus_req  out  1  high for the whole transaction; the top disables data drivers while it is high
- DAT_O  out  8  last byte read
- busy_flag  out  1  DAT_O[7] from the last RS=0 read
- addr_o  out  7  DAT_O[6:0] from the last RS=0 read
- timeout  out  1  poll limit reached with BF still 1
- end_strobe  out  1  one-cycle pulse when the transaction completes

Behaviour:
- Reset (asynchronous): state IDLE; lcd_e=0, lcd_rw=0, lcd_rs=0, bus_req=0, DAT_O=0, busy_flag=0, addr_o=0, timeout=0, end_strobe=0, counters 0.
- Reset mid-transaction: E drops immediately; no end_strobe is issued.
- States:
  - IDLE: start_strobe → SETUP; capture rs_sel and poll_mode; clear timeout; poll count=0.
  - SETUP (SETUP_CLKS cycles): bus_req=1, lcd_rw=1, lcd_rs=captured rs_sel, lcd_e=0. Then → EH1.
  - EH1 (E_HIGH_CLKS cycles): lcd_e=1. On the last cycle, register lcd_data_in into the high nibble. Then → EL1.
  - EL1 (E_LOW_CLKS cycles): lcd_e=0. Then → EH2.
  - EH2: as EH1, but sampled into the low nibble. Then → EL2.
  - EL2 (E_LOW_CLKS cycles), then the poll decision:
    - If poll active, BF=1 and poll count < MAX_POLLS-1: increment poll count, → EH1 with RS/RW held and no SETUP.
    - Otherwise → DONE.
  - DONE (1 cycle): end_strobe=1; DAT_O, busy_flag and addr_o updated in the same cycle (busy_flag/addr_o only if RS=0). timeout=1 if poll was active and BF is still 1. lcd_rw=0, bus_req=0. Then → IDLE.
- Timing and control rules:
  - lcd_rw and lcd_rs change only while E is low; E never glitches.
  - Latency: start sampled at edge k → end_strobe high in cycle k+1+SETUP_CLKS+2*(E_HIGH_CLKS+E_LOW_CLKS) = k+100 with defaults.
  - Each extra poll adds 96 cycles.
  - start_strobe while not IDLE is ignored; no queueing.
  - start_strobe in the DONE cycle is also ignored.
- Widths and value retention:
  - The poll counter is 8 bits and saturates; no wrap.
  - DAT_O holds its value until the next completion.
  - busy_flag and addr_o are untouched by RS=1 reads.
  - timeout holds until the next start.

Decomposition:
- Package hd44780_pkg holds:
  - the SYSFREQ-derived timing constants (SETUP_CLKS, E_HIGH_CLKS, E_LOW_CLKS);
  - the state encoding localparams (IDLE, SETUP, EH1, EL1, EH2, EL2, DONE);
  - RS code constants RS_CMD=0 and RS_DATA=1, shared with the writer.
- One sub-module, hd44780_phase_counter: loadable down-counter (load, value, done on reaching 1) with asynchronous active-high reset. It is reused by the writer later.

Test Plan:
- Single RS=0 read, lcd_data_in model returns 4'h3 then 4'hA:
  - end_strobe at k+100, DAT_O=8'h3A, busy_flag=0, addr_o=7'h3A;
  - E high exactly 24 cycles twice; RW high from k+1 to k+99.
- RS=1 read, model returns 4'hC then 4'h5:
  - DAT_O=8'hC5, lcd_rs=1 throughout;
  - busy_flag and addr_o keep their prior values.
- Poll mode, model returns BF=1 for 3 reads then byte 8'h12:
  - end_strobe at k+100+3*96=k+388, DAT_O=8'h12, timeout=0;
  - exactly 8 E pulses.
- Poll mode with BF stuck at 1 and MAX_POLLS=4: end_strobe after 4 byte reads, timeout=1, busy_flag=1.
- start_strobe pulsed at k+50 during a transaction: ignored; a single end_strobe at k+100.
- RST_I asserted asynchronously mid-EH1:
  - lcd_e, lcd_rw, bus_req go 0 before the next clock edge; no end_strobe.
  - A subsequent start completes normally.

Source files
------------

// File: rtl/hd44780_pkg.sv
// Shared HD44780 bus definitions: timing counts for a 48 MHz clock, state
// encoding of the read engine and the RS codes used by reader and writer.
package hd44780_pkg;

    localparam int unsigned SYSFREQ     = 48_000_000;
    // Counts below are pre-computed for SYSFREQ.
    localparam int unsigned SETUP_CLKS  = 3;
    localparam int unsigned E_HIGH_CLKS = 24;
    localparam int unsigned E_LOW_CLKS  = 24;
    localparam int unsigned MAX_POLLS   = 255;
    localparam int unsigned PHASE_BITS  = 5;

    localparam logic RS_CMD  = 1'b0;
    localparam logic RS_DATA = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        EH1,
        EL1,
        EH2,
        EL2,
        DONE
    } state_t;

endpackage

// File: rtl/hd44780_phase_counter.sv
// Loadable down-counter that times one bus phase; done is high while the
// count sits at 1, i.e. in the last cycle of the loaded phase.
module hd44780_phase_counter #(
    parameter int unsigned WIDTH = hd44780_pkg::PHASE_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == WIDTH'(1));

endmodule

// File: rtl/hd44780_bus_reader.sv
// HD44780 4-bit read engine: two E strobes per byte with nibble sampling at
// the end of each E-high phase, plus optional busy-flag polling.
module hd44780_bus_reader #(
    parameter int unsigned SETUP_CLKS  = hd44780_pkg::SETUP_CLKS,
    parameter int unsigned E_HIGH_CLKS = hd44780_pkg::E_HIGH_CLKS,
    parameter int unsigned E_LOW_CLKS  = hd44780_pkg::E_LOW_CLKS,
    parameter int unsigned MAX_POLLS   = hd44780_pkg::MAX_POLLS,
    parameter int unsigned PHASE_BITS  = hd44780_pkg::PHASE_BITS
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       start_strobe,
    input  logic       rs_sel,
    input  logic       poll_mode,
    input  logic [3:0] lcd_data_in,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic       bus_req,
    output logic [7:0] DAT_O,
    output logic       busy_flag,
    output logic [6:0] addr_o,
    output logic       timeout,
    output logic       end_strobe
);

    import hd44780_pkg::*;

    localparam logic [PHASE_BITS-1:0] SETUP_V = PHASE_BITS'(SETUP_CLKS);
    localparam logic [PHASE_BITS-1:0] EH_V    = PHASE_BITS'(E_HIGH_CLKS);
    localparam logic [PHASE_BITS-1:0] EL_V    = PHASE_BITS'(E_LOW_CLKS);
    localparam logic [7:0]            POLL_LAST = 8'(MAX_POLLS - 1);

    state_t                state;
    logic                  rs_cap;
    logic                  poll_cap;
    logic [7:0]            poll_cnt;
    logic [7:0]            rd_byte;
    logic                  ph_load;
    logic [PHASE_BITS-1:0] ph_value;
    logic                  ph_done;
    logic                  poll_active;
    logic                  poll_again;

    assign poll_active = poll_cap && (rs_cap == RS_CMD);
    assign poll_again  = poll_active && rd_byte[7] && (poll_cnt < POLL_LAST);

    hd44780_phase_counter #(
        .WIDTH(PHASE_BITS)
    ) u_phase (
        .clk  (CLK_I),
        .rst  (RST_I),
        .load (ph_load),
        .value(ph_value),
        .done (ph_done)
    );

    // Counter is reloaded on the same edge that moves the FSM to the next phase.
    always_comb begin
        ph_load  = 1'b0;
        ph_value = '0;
        case (state)
            IDLE: begin
                ph_load  = start_strobe;
                ph_value = SETUP_V;
            end
            SETUP, EL1: begin
                ph_load  = ph_done;
                ph_value = EH_V;
            end
            EH1, EH2: begin
                ph_load  = ph_done;
                ph_value = EL_V;
            end
            EL2: begin
                ph_load  = ph_done;
                ph_value = poll_again ? EH_V : '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state      <= IDLE;
            rs_cap     <= 1'b0;
            poll_cap   <= 1'b0;
            poll_cnt   <= '0;
            rd_byte    <= '0;
            lcd_rs     <= 1'b0;
            lcd_rw     <= 1'b0;
            lcd_e      <= 1'b0;
            bus_req    <= 1'b0;
            DAT_O      <= '0;
            busy_flag  <= 1'b0;
            addr_o     <= '0;
            timeout    <= 1'b0;
            end_strobe <= 1'b0;
        end else begin
            end_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_strobe) begin
                        state    <= SETUP;
                        rs_cap   <= rs_sel;
                        poll_cap <= poll_mode;
                        poll_cnt <= '0;
                        timeout  <= 1'b0;
                        bus_req  <= 1'b1;
                        lcd_rw   <= 1'b1;
                        lcd_rs   <= rs_sel;
                    end
                end
                SETUP: begin
                    if (ph_done) begin
                        state <= EH1;
                        lcd_e <= 1'b1;
                    end
                end
                EH1: begin
                    if (ph_done) begin
                        rd_byte[7:4] <= lcd_data_in;
                        lcd_e        <= 1'b0;
                        state        <= EL1;
                    end
                end
                EL1: begin
                    if (ph_done) begin
                        lcd_e <= 1'b1;
                        state <= EH2;
                    end
                end
                EH2: begin
                    if (ph_done) begin
                        rd_byte[3:0] <= lcd_data_in;
                        lcd_e        <= 1'b0;
                        state        <= EL2;
                    end
                end
                EL2: begin
                    if (ph_done) begin
                        if (poll_again) begin
                            // Re-poll straight into E high; RS/RW are still valid.
                            if (poll_cnt != 8'hFF) begin
                                poll_cnt <= poll_cnt + 8'd1;
                            end
                            lcd_e <= 1'b1;
                            state <= EH1;
                        end else begin
                            state      <= DONE;
                            end_strobe <= 1'b1;
                            DAT_O      <= rd_byte;
                            if (rs_cap == RS_CMD) begin
                                busy_flag <= rd_byte[7];
                                addr_o    <= rd_byte[6:0];
                            end
                            timeout <= poll_active && rd_byte[7];
                            lcd_rw  <= 1'b0;
                            bus_req <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hd44780_bus_reader.sv
// Scoreboard bench for hd44780_bus_reader: an LCD nibble model feeds reads,
// expected completions are queued at start and compared on end_strobe.
module tb_hd44780_bus_reader;

    localparam int unsigned E_HIGH = 24;
    localparam int unsigned BUDGET = 600;

    logic       clk;
    logic       rst;
    logic       start_strobe;
    logic       rs_sel;
    logic       poll_mode;
    logic [3:0] lcd_data_in;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic       bus_req;
    logic [7:0] DAT_O;
    logic       busy_flag;
    logic [6:0] addr_o;
    logic       timeout;
    logic       end_strobe;

    typedef struct {
        logic [7:0]  dat;
        logic        busy;
        logic [6:0]  addr;
        logic        to;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    logic [3:0]  nib_q[$];
    logic [3:0]  stuck_nib;
    int unsigned cyc;
    int unsigned checks;
    int unsigned errors;
    int unsigned e_run;
    int unsigned pulses;
    int unsigned rw_first;
    int unsigned rw_last;
    bit          rw_seen;

    hd44780_bus_reader #(
        .MAX_POLLS(4)
    ) dut (
        .CLK_I       (clk),
        .RST_I       (rst),
        .start_strobe(start_strobe),
        .rs_sel      (rs_sel),
        .poll_mode   (poll_mode),
        .lcd_data_in (lcd_data_in),
        .lcd_rs      (lcd_rs),
        .lcd_rw      (lcd_rw),
        .lcd_e       (lcd_e),
        .bus_req     (bus_req),
        .DAT_O       (DAT_O),
        .busy_flag   (busy_flag),
        .addr_o      (addr_o),
        .timeout     (timeout),
        .end_strobe  (end_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // LCD model: present the next nibble as soon as E rises.
    always @(posedge lcd_e) begin
        if (nib_q.size() != 0) lcd_data_in = nib_q.pop_front();
        else                   lcd_data_in = stuck_nib;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        nib_q.push_back(b[7:4]);
        nib_q.push_back(b[3:0]);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            e_run = 0;
        end else begin
            if (lcd_e) begin
                e_run++;
            end else if (e_run != 0) begin
                check("e_width", e_run, E_HIGH);
                e_run = 0;
                pulses++;
            end
            if (lcd_rw) begin
                if (!rw_seen) begin
                    rw_first = cyc;
                    rw_seen  = 1'b1;
                end
                rw_last = cyc;
            end
            if (end_strobe) begin
                if (sb.size() == 0) begin
                    check("spurious_end", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("end_cycle", cyc, e.cyc);
                    check("dat_o", DAT_O, e.dat);
                    check("busy_flag", busy_flag, e.busy);
                    check("addr_o", addr_o, e.addr);
                    check("timeout", timeout, e.to);
                    check("bus_req_done", bus_req, 0);
                end
            end
        end
    end

    task automatic run_read(input logic rs, input logic poll, input logic [7:0] edat,
                            input logic ebusy, input logic [6:0] eaddr, input logic eto,
                            input int unsigned extra, input int unsigned poke,
                            input int unsigned post);
        int unsigned k;
        int unsigned n;
        bit          rs_bad;
        exp_t        e;
        @(negedge clk);
        k            = cyc;
        rs_sel       = rs;
        poll_mode    = poll;
        start_strobe = 1'b1;
        e.dat  = edat;
        e.busy = ebusy;
        e.addr = eaddr;
        e.to   = eto;
        e.cyc  = k + 100 + 96 * extra;
        sb.push_back(e);
        pulses  = 0;
        rw_seen = 1'b0;
        rs_bad  = 1'b0;
        n       = 0;
        while ((sb.size() != 0 || (poke != 0 && cyc < k + poke)) && n < BUDGET) begin
            @(negedge clk);
            n++;
            start_strobe = (poke != 0 && cyc == k + poke);
            rs_sel       = start_strobe ? ~rs : rs;
            if (bus_req && lcd_rs !== rs) rs_bad = 1'b1;
        end
        check("end_seen", sb.size(), 0);
        sb.delete();
        repeat (post) begin
            @(negedge clk);
            start_strobe = 1'b0;
        end
        check("e_pulses", pulses, 2 * (extra + 1));
        check("rw_first", rw_first, k + 1);
        check("rw_last", rw_last, k + 99 + 96 * extra);
        check("rs_hold", rs_bad, 0);
    endtask

    initial begin
        int unsigned k;
        checks       = 0;
        errors       = 0;
        e_run        = 0;
        pulses       = 0;
        rw_seen      = 1'b0;
        rw_first     = 0;
        rw_last      = 0;
        stuck_nib    = 4'h0;
        lcd_data_in  = 4'h0;
        start_strobe = 1'b0;
        rs_sel       = 1'b0;
        poll_mode    = 1'b0;
        rst          = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_dat_o", DAT_O, 0);
        check("rst_busy", busy_flag, 0);
        check("rst_addr", addr_o, 0);
        check("rst_timeout", timeout, 0);
        check("rst_end", end_strobe, 0);
        check("rst_e", lcd_e, 0);
        check("rst_rw", lcd_rw, 0);
        check("rst_rs", lcd_rs, 0);
        check("rst_bus_req", bus_req, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        push_byte(8'h3A);
        run_read(1'b0, 1'b0, 8'h3A, 1'b0, 7'h3A, 1'b0, 0, 0, 5);

        push_byte(8'hC5);
        run_read(1'b1, 1'b0, 8'hC5, 1'b0, 7'h3A, 1'b0, 0, 0, 5);

        push_byte(8'h81);
        push_byte(8'h92);
        push_byte(8'hA3);
        push_byte(8'h12);
        run_read(1'b0, 1'b1, 8'h12, 1'b0, 7'h12, 1'b0, 3, 0, 5);

        stuck_nib = 4'h9;
        run_read(1'b0, 1'b1, 8'h99, 1'b1, 7'h19, 1'b1, 3, 0, 20);
        check("timeout_hold", timeout, 1);

        // Second start mid-transaction and in the DONE cycle must be dropped.
        push_byte(8'h56);
        run_read(1'b0, 1'b0, 8'h56, 1'b0, 7'h56, 1'b0, 0, 50, 110);

        push_byte(8'h84);
        run_read(1'b1, 1'b1, 8'h84, 1'b0, 7'h56, 1'b0, 0, 100, 110);

        @(negedge clk);
        k            = cyc;
        rs_sel       = 1'b0;
        poll_mode    = 1'b0;
        start_strobe = 1'b1;
        @(negedge clk);
        start_strobe = 1'b0;
        while (cyc < k + 10) @(negedge clk);
        check("e_before_rst", lcd_e, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_async_e", lcd_e, 0);
        check("rst_async_rw", lcd_rw, 0);
        check("rst_async_bus_req", bus_req, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_mid_dat_o", DAT_O, 0);
        check("rst_mid_addr", addr_o, 0);
        repeat (120) @(negedge clk);
        nib_q.delete();

        push_byte(8'h7F);
        run_read(1'b0, 1'b0, 8'h7F, 1'b0, 7'h7F, 1'b0, 0, 0, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
